voice_mix_scheduler: RTL and testbench
======================================

# voice_mix_scheduler

Per-sample scheduler that sequences the tracker's voice generators into the stereo PCM datapath. On each output-frame tick, it polls every enabled voice in fixed index order over a req/ack handshake and pans each returned sample into left/right accumulators. It then publishes one stereo 16-bit pair with a one-cycle valid strobe to the I2S serializer's PCM inputs. It sits between the voice/pattern engine and the PCM serializer.

## Interface
- NUM_VOICES, 4: number of voice requesters (2..16)
- SAMPLE_W, 16: signed sample width per voice and per output channel
- TIMEOUT_CYCLES, 64: max cycles a voice request may wait for ack
- clk  in  1  system clock; single clock domain
- reset_active_high  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per output sample period (48 kHz), already synchronous to clk
- voice_enable  in  NUM_VOICES  per-voice enable mask, sampled on accepted frame_tick
- voice_req  out  NUM_VOICES  one-hot request to voice i
- voice_ack  in  NUM_VOICES  voice i presents valid sample/pan this cycle
- voice_sample  in  NUM_VOICES*SAMPLE_W  signed samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
- voice_pan  in  NUM_VOICES*2  pan codes: 00 both, 01 left only, 10 right only, 11 mute
- clear_status  in  1  clears sticky flags
- pcm_left / pcm_right  out  SAMPLE_W each  published stereo pair, held until next publish
- pcm_valid  out  1  one-cycle strobe when the pcm pair updates
- busy  out  1  high from frame acceptance through the publish cycle
- overrun  out  1  sticky: frame_tick arrived while busy
- timeout_voice  out  NUM_VOICES  sticky: voice i timed out

## Operation
- States: IDLE, POLL, PUBLISH.
- IDLE: on frame_tick, latch voice_enable, clear accumulators, set idx=0, go to POLL.
- POLL, voice idx enabled: assert voice_req[idx] (only that bit).
  - When voice_ack[idx] is high: add the sample per pan code. 00 adds to both accumulators, 01 adds to left, 10 adds to right, 11 adds nothing.
  - On a timeout (see below), add nothing, set timeout_voice[idx], and advance.
- POLL, voice idx disabled: spend exactly one cycle with no request, then advance.
- Advance: idx+1, or PUBLISH if idx was NUM_VOICES-1.
- PUBLISH: register the clamped/truncated sums into pcm_left and pcm_right, pulse pcm_valid, then return to IDLE.
- Accumulators are SAMPLE_W+clog2(NUM_VOICES)+1 bits, signed, sign-extending each sample.
- Ack without a matching request, or ack on a non-polled index, is ignored.
- A frame_tick outside IDLE is dropped and sets overrun. The in-flight frame is unaffected.
- clear_status clears overrun and timeout_voice. If a set and a clear land in the same cycle, the set wins.
- Reset (any time, including mid-frame): return to IDLE. All outputs go to 0, accumulators clear, and no pcm_valid is emitted for the aborted frame.

## Timing
- frame_tick is accepted in cycle 0. voice_req for voice 0 is asserted in cycle 1.
- Ack is accepted in the same cycle voice_req is high. voice_req drops in the following cycle, and the next index's request appears in that cycle.
- With all voices acking immediately, or disabled: the last voice finishes in cycle NUM_VOICES, and pcm_valid with the new pcm pair appears in cycle NUM_VOICES+1. busy is high in cycles 1..NUM_VOICES+1.
- Each ack wait adds its wait cycles to this latency.
- The timeout counter restarts at each new request. If there is no ack by the TIMEOUT_CYCLES-th cycle of the request, the voice times out. An ack in that same cycle wins, and no timeout is flagged.
- Worst-case frame: NUM_VOICES*TIMEOUT_CYCLES+1 cycles. This must stay under the frame period.

## Configuration
- MIXER_SATURATE_EN defined: final sums are clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- MIXER_SATURATE_EN undefined: the low SAMPLE_W bits of each sum are output (two's-complement wrap).

## Structure
- Package tracker_mix_pkg contains:
  - the state enum;
  - pan code constants PAN_BOTH, PAN_LEFT, PAN_RIGHT, PAN_MUTE;
  - the accumulator-width function.
- Sub-module pcm_saturator is combinational, parameterised by input width and SAMPLE_W, and instantiated once per channel. It contains both the saturate and wrap paths selected by MIXER_SATURATE_EN.

## Test plan
- NUM_VOICES=4, all enabled, immediate acks, samples 100/200/-50/1000, pans 00/01/10/00:
  - pcm_left=1300 and pcm_right=1050;
  - pcm_valid in cycle 5 after frame_tick.
- Four voices at 30000 with pan 00:
  - with MIXER_SATURATE_EN, both channels are 32767;
  - without it, both channels are 120000 mod 65536 as signed = -11072.
- voice_enable=4'b0101 and voices 1/3 driving ack with nonzero samples: voice_req never targets 1 or 3, their samples are excluded, and latency is unchanged (cycle 5).
- Voice 2 never acks, TIMEOUT_CYCLES=64:
  - timeout_voice=4'b0100;
  - the voice 2 sample is treated as 0;
  - pcm_valid arrives in cycle 68;
  - clear_status then clears the flag.
- A second frame_tick 2 cycles after the first: overrun=1, exactly one pcm_valid is emitted, and the first frame's result is correct.
- Assert reset_active_high while voice 1 is being polled: voice_req goes to 0 immediately, no pcm_valid is emitted, and pcm_left/pcm_right read 0. The next frame_tick then produces a correct frame.

Source files
------------

// File: rtl/tracker_mix_pkg.sv
// Shared definitions for the voice mix scheduler: FSM state encoding,
// pan code constants and the accumulator width helper.
package tracker_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POLL    = 2'd1,
        ST_PUBLISH = 2'd2
    } mix_state_t;

    localparam logic [1:0] PAN_BOTH  = 2'b00;
    localparam logic [1:0] PAN_LEFT  = 2'b01;
    localparam logic [1:0] PAN_RIGHT = 2'b10;
    localparam logic [1:0] PAN_MUTE  = 2'b11;

    // Headroom for summing num_voices full-scale samples plus one guard bit.
    function automatic int acc_width(input int sample_w, input int num_voices);
        return sample_w + $clog2(num_voices) + 1;
    endfunction

endpackage

// File: rtl/pcm_saturator.sv
// Combinational reduction of a wide signed mix sum to a PCM sample.
// Build option MIXER_SATURATE_EN: clamp to the PCM range; otherwise the
// low SAMPLE_W bits are passed through (two's-complement wrap).
module pcm_saturator #(
    parameter int IN_W     = 19,
    parameter int SAMPLE_W = 16
) (
    input  logic signed [IN_W-1:0]     sum_in,
    output logic signed [SAMPLE_W-1:0] pcm_out
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (SAMPLE_W - 1)) - 1);
    // Bitwise inverse of 0..0111..1 is the most negative PCM value, sign-extended.
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [IN_W-1:0] v);
        if (v > MAX_V) return SAMPLE_W'(MAX_V);
        if (v < MIN_V) return SAMPLE_W'(MIN_V);
        return SAMPLE_W'(v);
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] wrap(input logic signed [IN_W-1:0] v);
        return SAMPLE_W'(v);
    endfunction

    // Select the reduction policy chosen at build time.
    always_comb begin
`ifdef MIXER_SATURATE_EN
        pcm_out = saturate(sum_in);
`else
        pcm_out = wrap(sum_in);
`endif
    end

endmodule

// File: rtl/voice_mix_scheduler.sv
// Per-frame voice polling scheduler and stereo mixer.
// Each accepted frame_tick walks the voices in index order over req/ack,
// pans the returned samples into left/right accumulators and publishes one
// stereo PCM pair. Build option MIXER_SATURATE_EN selects clamping instead of
// wrap for the published pair (see pcm_saturator).
module voice_mix_scheduler
    import tracker_mix_pkg::*;
#(
    parameter int NUM_VOICES     = 4,
    parameter int SAMPLE_W       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset_active_high,
    input  logic                           frame_tick,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    output logic [NUM_VOICES-1:0]          voice_req,
    input  logic [NUM_VOICES-1:0]          voice_ack,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES*2-1:0]        voice_pan,
    input  logic                           clear_status,
    output logic [SAMPLE_W-1:0]            pcm_left,
    output logic [SAMPLE_W-1:0]            pcm_right,
    output logic                           pcm_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [NUM_VOICES-1:0]          timeout_voice
);

    localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mix_state_t              state;
    mix_state_t              state_next;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        wait_cnt;
    logic [NUM_VOICES-1:0]   enable_lat;
    logic signed [ACC_W-1:0] acc_left;
    logic signed [ACC_W-1:0] acc_right;
    logic signed [ACC_W-1:0] acc_left_next;
    logic signed [ACC_W-1:0] acc_right_next;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [SAMPLE_W-1:0] cur_sample;
    logic signed [SAMPLE_W-1:0] left_reduced;
    logic signed [SAMPLE_W-1:0] right_reduced;
    logic [1:0]              cur_pan;
    logic                    cur_enabled;
    logic                    in_poll;
    logic                    accept;
    logic                    ack_hit;
    logic                    timed_out;
    logic                    advance;
    logic                    last_idx;

    // Decode the voice currently being polled and the events that end its slot.
    always_comb begin
        in_poll     = (state == ST_POLL);
        accept      = (state == ST_IDLE) && frame_tick;
        cur_enabled = enable_lat[idx];
        cur_sample  = voice_sample[idx*SAMPLE_W +: SAMPLE_W];
        cur_pan     = voice_pan[idx*2 +: 2];
        sample_ext  = ACC_W'(cur_sample);
        // Only an ack on the polled, enabled voice counts; an ack in the final
        // wait cycle beats the timeout.
        ack_hit     = in_poll && cur_enabled && voice_ack[idx];
        timed_out   = in_poll && cur_enabled && !voice_ack[idx]
                      && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        advance     = in_poll && (!cur_enabled || ack_hit || timed_out);
        last_idx    = (idx == IDX_W'(NUM_VOICES - 1));
    end

    // Pan the accepted sample into the accumulators.
    always_comb begin
        acc_left_next  = acc_left;
        acc_right_next = acc_right;
        if (ack_hit) begin
            if (cur_pan == PAN_BOTH || cur_pan == PAN_LEFT)
                acc_left_next = acc_left + sample_ext;
            if (cur_pan == PAN_BOTH || cur_pan == PAN_RIGHT)
                acc_right_next = acc_right + sample_ext;
        end
    end

    pcm_saturator #(.IN_W(ACC_W), .SAMPLE_W(SAMPLE_W)) u_sat_left (
        .sum_in  (acc_left_next),
        .pcm_out (left_reduced)
    );

    pcm_saturator #(.IN_W(ACC_W), .SAMPLE_W(SAMPLE_W)) u_sat_right (
        .sum_in  (acc_right_next),
        .pcm_out (right_reduced)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset_active_high) begin
        if (reset_active_high) state <= ST_IDLE;
        else                   state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (frame_tick) state_next = ST_POLL;
            ST_POLL:    if (advance && last_idx) state_next = ST_PUBLISH;
            ST_PUBLISH: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: one-hot request to the polled enabled voice, busy, publish strobe.
    always_comb begin
        voice_req = '0;
        if (in_poll && cur_enabled) voice_req[idx] = 1'b1;
        busy      = (state != ST_IDLE);
        pcm_valid = (state == ST_PUBLISH);
    end

    // Frame datapath: enable latch, voice index, wait counter, accumulators and
    // the published pair. The pair is loaded as the last voice finishes so it is
    // already visible during the publish cycle alongside pcm_valid.
    always_ff @(posedge clk or posedge reset_active_high) begin
        if (reset_active_high) begin
            enable_lat <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            acc_left   <= '0;
            acc_right  <= '0;
            pcm_left   <= '0;
            pcm_right  <= '0;
        end else if (accept) begin
            enable_lat <= voice_enable;
            idx        <= '0;
            wait_cnt   <= '0;
            acc_left   <= '0;
            acc_right  <= '0;
        end else if (in_poll) begin
            acc_left  <= acc_left_next;
            acc_right <= acc_right_next;
            if (advance) begin
                wait_cnt <= '0;
                if (last_idx) begin
                    pcm_left  <= left_reduced;
                    pcm_right <= right_reduced;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Sticky status flags; a set in the same cycle as clear_status wins.
    always_ff @(posedge clk or posedge reset_active_high) begin
        if (reset_active_high) begin
            overrun       <= 1'b0;
            timeout_voice <= '0;
        end else begin
            if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
            else if (clear_status)              overrun <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (timed_out && idx == IDX_W'(i)) timeout_voice[i] <= 1'b1;
                else if (clear_status)             timeout_voice[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Self-checking bench for voice_mix_scheduler (NUM_VOICES=4, TIMEOUT_CYCLES=64).
// Voice responders ack after a programmable delay; a frame-level model
// predicts the stereo pair, publish latency and timeout flags.
module tb_voice_mix_scheduler;

    localparam int NV = 4;
    localparam int SW = 16;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic [NV-1:0]     voice_enable = '0;
    logic [NV-1:0]     voice_req;
    logic [NV-1:0]     voice_ack;
    logic [NV*SW-1:0]  voice_sample;
    logic [NV*2-1:0]   voice_pan;
    logic              clear_status = 1'b0;
    logic [SW-1:0]     pcm_left;
    logic [SW-1:0]     pcm_right;
    logic              pcm_valid;
    logic              busy;
    logic              overrun;
    logic [NV-1:0]     timeout_voice;

    int checks = 0;
    int failures = 0;

    int smp[NV];
    int pan[NV];
    int dly[NV];       // ack in cycle dly+1 of the request; negative = never
    logic [NV-1:0] ack_force = '0;
    logic [NV-1:0] cur_mask = '0;
    int req_age[NV];
    int pv_count = 0;
    int bad_req = 0;

    voice_mix_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset_active_high (rst),
        .frame_tick        (frame_tick),
        .voice_enable      (voice_enable),
        .voice_req         (voice_req),
        .voice_ack         (voice_ack),
        .voice_sample      (voice_sample),
        .voice_pan         (voice_pan),
        .clear_status      (clear_status),
        .pcm_left          (pcm_left),
        .pcm_right         (pcm_right),
        .pcm_valid         (pcm_valid),
        .busy              (busy),
        .overrun           (overrun),
        .timeout_voice     (timeout_voice)
    );

    always #5 clk = ~clk;

    // Voice responders.
    always_comb begin
        voice_ack    = '0;
        voice_sample = '0;
        voice_pan    = '0;
        for (int i = 0; i < NV; i++) begin
            voice_sample[i*SW +: SW] = SW'(smp[i]);
            voice_pan[i*2 +: 2]      = 2'(pan[i]);
            voice_ack[i] = ack_force[i] |
                           (voice_req[i] && dly[i] >= 0 && req_age[i] >= dly[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NV; i++) req_age[i] <= voice_req[i] ? req_age[i] + 1 : 0;
        if (pcm_valid) pv_count <= pv_count + 1;
        if ($countones(voice_req) > 1 || (voice_req & ~cur_mask) != 0) bad_req <= bad_req + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fold(input int v);
`ifdef MIXER_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        int m;
        m = ((v % 65536) + 65536) % 65536;
        return (m >= 32768) ? m - 65536 : m;
`endif
    endfunction

    // Runs one frame and checks it against the model. tick2 > 0 injects a second
    // frame_tick in that cycle (with clear_status if clr2).
    task automatic run_frame(input string tag, input logic [NV-1:0] en,
                             input int tick2, input bit clr2);
        int sum_l, sum_r, lat, cyc, pv0;
        logic [NV-1:0] exp_to;
        sum_l = 0; sum_r = 0; lat = 1; exp_to = '0;
        for (int i = 0; i < NV; i++) begin
            if (!en[i]) lat += 1;
            else if (dly[i] < 0 || dly[i] >= TO) begin
                lat += TO;
                exp_to[i] = 1'b1;
            end else begin
                lat += dly[i] + 1;
                if (pan[i] == 0 || pan[i] == 1) sum_l += smp[i];
                if (pan[i] == 0 || pan[i] == 2) sum_r += smp[i];
            end
        end
        @(negedge clk); clear_status = 1'b1;
        @(negedge clk); clear_status = 1'b0;
        voice_enable = en; cur_mask = en; frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk); frame_tick = 1'b0; voice_enable = ~en;
        cyc = 1; pv0 = pv_count;
        while (!pcm_valid && cyc < 2000) begin
            if (cyc == tick2) begin frame_tick = 1'b1; clear_status = clr2; end
            @(negedge clk);
            frame_tick = 1'b0; clear_status = 1'b0;
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_left"}, $signed(pcm_left), fold(sum_l));
        check({tag, "_right"}, $signed(pcm_right), fold(sum_r));
        check({tag, "_busy_pub"}, busy, 1);
        @(negedge clk);
        check({tag, "_one_valid"}, pv_count - pv0, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_timeouts"}, timeout_voice, exp_to);
        check({tag, "_req_rule"}, bad_req, 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NV; i++) begin smp[i] = 0; pan[i] = 0; dly[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_req", voice_req, 0);
        check("rst_left", pcm_left, 0);
        check("rst_right", pcm_right, 0);
        check("rst_valid", pcm_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_voice, 0);
        rst = 1'b0;

        // Basic mix.
        smp = '{100, 200, -50, 1000}; pan = '{0, 1, 2, 0};
        run_frame("basic", 4'b1111, 0, 0);

        // Overflow of the output range.
        smp = '{30000, 30000, 30000, 30000}; pan = '{0, 0, 0, 0};
        run_frame("overflow", 4'b1111, 0, 0);

        // Disabled voices acking spuriously must be ignored.
        smp = '{7, 1111, -3, 2222}; pan = '{0, 0, 0, 0}; ack_force = 4'b1010;
        run_frame("masked", 4'b0101, 0, 0);
        ack_force = '0;

        // Voice 2 never acks: timeout, then clear.
        smp = '{10, 20, 5000, 40}; pan = '{0, 1, 0, 2}; dly = '{0, 0, -1, 0};
        run_frame("timeout", 4'b1111, 0, 0);
        @(negedge clk); clear_status = 1'b1;
        @(negedge clk); clear_status = 1'b0;
        check("timeout_cleared", timeout_voice, 0);

        // Ack in the final wait cycle wins over the timeout.
        dly = '{0, TO - 1, 2, 0};
        run_frame("last_cycle_ack", 4'b1111, 0, 0);

        // Second tick while busy.
        dly = '{1, 0, 0, 3}; smp = '{-400, 300, 200, 100}; pan = '{0, 0, 3, 1};
        run_frame("overrun", 4'b1111, 2, 0);
        check("overrun_set", overrun, 1);
        // Set and clear in the same cycle: the set wins.
        run_frame("overrun_vs_clear", 4'b1111, 2, 1);
        check("overrun_set_wins", overrun, 1);
        @(negedge clk); clear_status = 1'b1;
        @(negedge clk); clear_status = 1'b0;
        check("overrun_cleared", overrun, 0);

        // Reset while voice 1 is polled.
        dly = '{0, 10, 0, 0}; cur_mask = 4'b1111;
        @(negedge clk); voice_enable = 4'b1111; frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        check("abort_req_before", voice_req, 4'b0010);
        cyc = pv_count;
        rst = 1'b1;
        #1;
        check("abort_req", voice_req, 0);
        check("abort_left", pcm_left, 0);
        check("abort_right", pcm_right, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_valid", pv_count - cyc, 0);
        dly = '{0, 0, 0, 0}; smp = '{1, 2, 3, 4}; pan = '{0, 0, 0, 0};
        run_frame("after_abort", 4'b1111, 0, 0);

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            logic [NV-1:0] en;
            en = 4'($urandom_range(0, 15));
            for (int i = 0; i < NV; i++) begin
                int r;
                smp[i] = int'($urandom_range(0, 65535)) - 32768;
                pan[i] = int'($urandom_range(0, 3));
                r = int'($urandom_range(0, 9));
                dly[i] = (r == 9) ? -1 : r % 4;
            end
            run_frame("random", en, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
